// File: rtl/rng_pkg.sv
// Shared definitions for the RNG-2D generator datapath: sequencer states and
// default seed/width constants.
package rng_pkg;

    localparam int          RNG_SEED_W       = 16;
    localparam logic [15:0] RNG_DEFAULT_SEED = 16'h5555;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WARM  = 2'd2,
        SERVE = 2'd3
    } state_t;

endpackage

// File: rtl/seed_sequencer.sv
// Seed sequencer: captures a seed, loads and warms up an external LFSR, then
// serves LFSR words over valid/ready with automatic reseeding every RESEED_PERIOD draws.
module seed_sequencer
    import rng_pkg::*;
#(
    parameter int                SEED_W        = RNG_SEED_W,
    parameter int                WARMUP        = 32,
    parameter int                RESEED_PERIOD = 1024,
    parameter logic [SEED_W-1:0] DEFAULT_SEED  = SEED_W'(RNG_DEFAULT_SEED)
) (
    input  logic              CLK500Hz,
    input  logic              rstn,
    input  logic [SEED_W-1:0] seed_in,
    input  logic              start,
    input  logic [SEED_W-1:0] lfsr_q,
    output logic              lfsr_load,
    output logic [SEED_W-1:0] lfsr_seed,
    output logic              lfsr_step,
    output logic              rnd_valid,
    output logic [SEED_W-1:0] rnd_data,
    input  logic              rnd_ready,
    output logic              busy,
    output logic [7:0]        reseed_cnt
);

    localparam int WARM_W = $clog2(WARMUP + 1);
    localparam int DRAW_W = $clog2(RESEED_PERIOD + 1);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP - 1);
    localparam logic [DRAW_W-1:0] DRAW_LAST = DRAW_W'(RESEED_PERIOD - 1);

    state_t              state_reg, state_next;
    logic [SEED_W-1:0]   seed_reg, seed_next;
    logic [WARM_W-1:0]   warm_cnt_reg, warm_cnt_next;
    logic [DRAW_W-1:0]   draw_cnt_reg, draw_cnt_next;
    logic [7:0]          reseed_cnt_reg, reseed_cnt_next;

    logic handshake;
    logic period_done;
    logic capture;

    assign handshake   = (state_reg == SERVE) && rnd_ready;
    assign period_done = handshake && (draw_cnt_reg == DRAW_LAST);

    always_ff @(posedge CLK500Hz) begin
        if (rstn) begin
            state_reg      <= IDLE;
            seed_reg       <= DEFAULT_SEED;
            warm_cnt_reg   <= '0;
            draw_cnt_reg   <= '0;
            reseed_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            seed_reg       <= seed_next;
            warm_cnt_reg   <= warm_cnt_next;
            draw_cnt_reg   <= draw_cnt_next;
            reseed_cnt_reg <= reseed_cnt_next;
        end
    end

    // A period-completing handshake and a start request both lead to LOAD;
    // only the former counts as an automatic reseed.
    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                    capture    = 1'b1;
                end
            end
            LOAD: state_next = WARM;
            WARM: begin
                if (warm_cnt_reg == WARM_LAST) begin
                    state_next = SERVE;
                end
            end
            SERVE: begin
                if (period_done || start) begin
                    state_next = LOAD;
                    capture    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        seed_next       = seed_reg;
        warm_cnt_next   = warm_cnt_reg;
        draw_cnt_next   = draw_cnt_reg;
        reseed_cnt_next = reseed_cnt_reg;
        if (capture) begin
            seed_next = (seed_in == '0) ? DEFAULT_SEED : seed_in;
        end
        if (state_reg == LOAD) begin
            warm_cnt_next = '0;
            draw_cnt_next = '0;
        end
        if (state_reg == WARM) begin
            warm_cnt_next = warm_cnt_reg + 1'b1;
        end
        if (handshake) begin
            draw_cnt_next = draw_cnt_reg + 1'b1;
        end
        if (period_done && (reseed_cnt_reg != 8'hFF)) begin
            reseed_cnt_next = reseed_cnt_reg + 8'd1;
        end
    end

    always_comb begin
        lfsr_load = 1'b0;
        lfsr_seed = '0;
        lfsr_step = 1'b0;
        rnd_valid = 1'b0;
        rnd_data  = '0;
        busy      = 1'b0;
        case (state_reg)
            LOAD: begin
                lfsr_load = 1'b1;
                lfsr_seed = seed_reg;
                busy      = 1'b1;
            end
            WARM: begin
                lfsr_step = 1'b1;
                busy      = 1'b1;
            end
            SERVE: begin
                rnd_valid = 1'b1;
                rnd_data  = lfsr_q;
                lfsr_step = rnd_ready;
            end
            default: ;
        endcase
    end

    assign reseed_cnt = reseed_cnt_reg;

endmodule

// File: tb/tb_seed_sequencer.sv
// Bench for seed_sequencer: directed and random serve traffic checked against
// an arithmetic model (word = k-th LFSR successor of the effective seed).
module tb_seed_sequencer;

    localparam int W      = 16;
    localparam int WARMUP = 32;
    localparam int PERIOD = 4;

    logic         CLK500Hz = 1'b0;
    logic         rstn = 1'b1;
    logic         start = 1'b0;
    logic         rnd_ready = 1'b0;
    logic [W-1:0] seed_in = '0;
    logic [W-1:0] lfsr_q;
    logic         lfsr_load, lfsr_step, rnd_valid, busy;
    logic [W-1:0] lfsr_seed, rnd_data;
    logic [7:0]   reseed_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int draws = 0;
    int rc = 0;
    logic [W-1:0] cur_seed = '0;
    logic [W-1:0] ref_q = '0;

    always #5 CLK500Hz = ~CLK500Hz;

    seed_sequencer #(
        .SEED_W(W), .WARMUP(WARMUP), .RESEED_PERIOD(PERIOD), .DEFAULT_SEED(16'h5555)
    ) dut (
        .CLK500Hz(CLK500Hz), .rstn(rstn), .seed_in(seed_in), .start(start),
        .lfsr_q(lfsr_q), .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed),
        .lfsr_step(lfsr_step), .rnd_valid(rnd_valid), .rnd_data(rnd_data),
        .rnd_ready(rnd_ready), .busy(busy), .reseed_cnt(reseed_cnt)
    );

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[0] ^ q[2] ^ q[3] ^ q[5], q[15:1]};
    endfunction

    function automatic logic [15:0] succ(input logic [15:0] s, input int n);
        logic [15:0] q;
        q = s;
        for (int i = 0; i < n; i++) q = lfsr_next(q);
        return q;
    endfunction

    function automatic logic [15:0] eff_seed(input logic [15:0] s);
        return (s == 16'h0) ? 16'h5555 : s;
    endfunction

    // External 16-bit LFSR driven by the block under test
    assign lfsr_q = ref_q;
    always @(posedge CLK500Hz) begin
        if (lfsr_load) ref_q <= lfsr_seed;
        else if (lfsr_step) ref_q <= lfsr_next(ref_q);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK500Hz);
        #1;
    endtask

    // Entered on the LOAD cycle; walks LOAD + WARM and checks the first served word.
    task automatic expect_load_warm(input logic [15:0] exp_seed, input string tag, input bit poke);
        int steps, loads, valids, busys;
        steps = 0; loads = 0; valids = 0; busys = 0;
        start = 1'b0;
        #1;
        chk({tag, "_load"}, lfsr_load, 1);
        chk({tag, "_seed"}, lfsr_seed, exp_seed);
        chk({tag, "_load_nostep"}, {lfsr_step, rnd_valid, busy}, 3'b001);
        chk({tag, "_reseed_cnt"}, reseed_cnt, rc);
        cyc();
        for (int i = 0; i < WARMUP; i++) begin
            start = (poke && i == WARMUP / 2);
            if (start) seed_in = W'($urandom);
            #1;
            steps += int'(lfsr_step);
            loads += int'(lfsr_load);
            valids += int'(rnd_valid);
            busys += int'(busy);
            cyc();
        end
        start = 1'b0;
        rnd_ready = 1'b0;
        #1;
        chk({tag, "_warm_steps"}, steps, WARMUP);
        chk({tag, "_warm_noload_novalid"}, {loads, valids}, 0);
        chk({tag, "_warm_busy"}, busys, WARMUP);
        chk({tag, "_first_valid"}, {rnd_valid, busy}, 2'b10);
        chk({tag, "_first_word"}, rnd_data, succ(exp_seed, WARMUP));
        cur_seed = exp_seed;
        draws = 0;
        $display("txn %s: seed=%h first_word=%h reseeds=%0d", tag, exp_seed, rnd_data, rc);
    endtask

    task automatic launch(input logic [15:0] sd, input string tag);
        start = 1'b1;
        seed_in = sd;
        rnd_ready = 1'($urandom_range(0, 1));
        #1;
        chk({tag, "_idle_outputs"},
            {lfsr_load, lfsr_step, rnd_valid, busy, lfsr_seed, rnd_data}, 64'h0);
        cyc();
        seed_in = W'($urandom);
        expect_load_warm(eff_seed(sd), tag, 1'b0);
    endtask

    // One SERVE cycle with the model deciding whether a (re)load follows.
    task automatic serve(input bit rdy, input bit st, input logic [15:0] sd,
                         input bit poke, output logic [15:0] seen);
        rnd_ready = rdy;
        start = st;
        seed_in = sd;
        #1;
        seen = rnd_data;
        chk("serve_valid", {rnd_valid, busy, lfsr_load}, 3'b100);
        chk("serve_data", rnd_data, succ(cur_seed, WARMUP + draws));
        chk("serve_step", lfsr_step, rdy);
        $display("txn serve: ready=%0b start=%0b data=%h draws=%0d", rdy, st, rnd_data, draws);
        cyc();
        rnd_ready = 1'b0;
        start = 1'b0;
        if (rdy) draws++;
        if (rdy && draws == PERIOD) begin
            rc = (rc < 255) ? rc + 1 : 255;
            expect_load_warm(eff_seed(sd), "auto", poke);
        end else if (st) begin
            expect_load_warm(eff_seed(sd), "restart", poke);
        end
    endtask

    initial begin
        logic [15:0] w0, w1, w2, seen;
        bit found;
        rstn = 1'b1;
        cyc();
        cyc();
        rstn = 1'b0;
        #1;
        chk("reset_outputs", {lfsr_load, lfsr_step, rnd_valid, busy, lfsr_seed, rnd_data}, 64'h0);
        chk("reset_reseed_cnt", reseed_cnt, 0);
        cyc();

        launch(16'hACE1, "basic");

        // Backpressure, then three accepted words
        repeat (10) serve(1'b0, 1'b0, W'($urandom), 1'b0, seen);
        serve(1'b1, 1'b0, W'($urandom), 1'b0, w0);
        serve(1'b1, 1'b0, W'($urandom), 1'b0, w1);
        serve(1'b1, 1'b0, W'($urandom), 1'b0, w2);
        chk("distinct_words", (w0 != w1) && (w1 != w2) && (w0 != w2), 1);

        // Fourth handshake completes the period and reseeds from 1234
        serve(1'b1, 1'b0, 16'h1234, 1'b0, seen);
        chk("auto_reseed_cnt", reseed_cnt, 1);

        // Restart from SERVE with a start pulse poked mid-WARM
        serve(1'b1, 1'b0, W'($urandom), 1'b0, seen);
        serve(1'b0, 1'b1, 16'hBEEF, 1'b1, seen);

        // Zero seed substitutes the default
        serve(1'b1, 1'b1, 16'h0000, 1'b0, seen);

        // start together with the period-completing handshake
        repeat (3) serve(1'b1, 1'b0, W'($urandom), 1'b0, seen);
        serve(1'b1, 1'b1, 16'h7777, 1'b0, seen);

        for (int i = 0; i < 80; i++) begin
            serve(1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 3) == 0) ? 16'h0 : W'($urandom),
                  1'($urandom_range(0, 1)), seen);
        end

        // Saturation of the reseed counter under continuous draws
        rnd_ready = 1'b1;
        repeat (260 * (PERIOD + WARMUP + 1)) cyc();
        rc = 255;
        #1;
        chk("reseed_saturate", reseed_cnt, 255);
        $display("txn saturate: reseed_cnt=%0d", reseed_cnt);

        rnd_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2 * (WARMUP + 2) && !found; i++) begin
            if (rnd_valid) found = 1'b1;
            else cyc();
        end
        chk("serve_reached", found, 1);

        // Reset in the middle of a handshake
        rnd_ready = 1'b1;
        rstn = 1'b1;
        cyc();
        rstn = 1'b0;
        #1;
        chk("midserve_reset_outputs",
            {lfsr_load, lfsr_step, rnd_valid, busy, lfsr_seed, rnd_data}, 64'h0);
        chk("midserve_reset_cnt", reseed_cnt, 0);
        rc = 0;
        cyc();
        launch(16'hACE1, "again");
        serve(1'b1, 1'b0, W'($urandom), 1'b0, seen);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seed_sequencer.md
# seed_sequencer

Controller that sequences the RNG-2D generator datapath. It captures a seed from the seed source and loads it into the LFSR. It then steps the LFSR through a fixed warm-up, serves random words to a consumer over a valid/ready handshake, and reseeds automatically after a configurable number of draws. It sits between the seed source, the LFSR core and the downstream consumer (display/coordinate logic).

## Interface
Parameters:
- SEED_W, 16, width of seed and LFSR state
- WARMUP, 32, LFSR steps discarded after every load (≥1)
- RESEED_PERIOD, 1024, accepted draws between automatic reseeds (≥1)
- DEFAULT_SEED, 16'h5555, substitute when the captured seed is all-zero

Ports:
- CLK500Hz  in  1  system clock; single clock domain
- rstn  in  1  reset, synchronous, active-high
- seed_in  in  SEED_W  seed source value, sampled only at capture points
- start  in  1  request (re)seed sequence
- lfsr_q  in  SEED_W  current LFSR state
- lfsr_load  out  1  one-cycle load strobe to LFSR
- lfsr_seed  out  SEED_W  value to load, valid while lfsr_load=1
- lfsr_step  out  1  advance LFSR one step this cycle
- rnd_valid  out  1  rnd_data holds a fresh word
- rnd_data  out  SEED_W  random word output
- rnd_ready  in  1  consumer accepts word
- busy  out  1  high in LOAD or WARM
- reseed_cnt  out  8  count of automatic reseeds, saturates at 255

## Operation
- States: IDLE, LOAD, WARM, SERVE.
- IDLE: all outputs 0. start=1 → capture seed, go to LOAD.
- Seed capture: seed_reg ← (seed_in==0) ? DEFAULT_SEED : seed_in.
- LOAD (exactly 1 cycle):
  - lfsr_load=1, lfsr_seed=seed_reg.
  - Clear warm counter and draw counter.
  - → WARM.
- WARM:
  - lfsr_step=1 every cycle; warm counter increments.
  - After WARMUP steps → SERVE.
  - start ignored.
- SERVE:
  - rnd_valid=1; rnd_data=lfsr_q.
  - Handshake (rnd_valid & rnd_ready): lfsr_step=1 the same cycle; draw counter +1.
  - Handshake that makes draw counter reach RESEED_PERIOD: capture seed_in that cycle, reseed_cnt +1 (saturating), → LOAD.
  - start=1 with no period-completing handshake: capture seed, → LOAD; reseed_cnt unchanged. Any concurrent handshake still completes and steps the LFSR.
  - start=1 together with a period-completing handshake: treated as the automatic reseed; reseed_cnt increments once.
- rnd_data driven 0 whenever rnd_valid=0.
- lfsr_load and lfsr_step never asserted in the same cycle.
- Draw counter width: clog2(RESEED_PERIOD+1). Warm counter width: clog2(WARMUP+1).

## Timing
- Reset (rstn=1 at a clock edge) → next cycle: state IDLE, all outputs 0, seed_reg=DEFAULT_SEED, all counters 0.
- Reset takes priority over every other input, including mid-LOAD, mid-WARM and mid-handshake.
- start sampled at edge t → lfsr_load high in cycle t+1 → lfsr_step high in cycles t+2 … t+1+WARMUP → rnd_valid high from cycle t+2+WARMUP.
- Start-to-first-valid latency: WARMUP+2 cycles.
- In SERVE, rnd_valid stays high and rnd_data stays stable until a handshake occurs. After a non-final handshake, the next word appears the following cycle (LFSR has stepped); rnd_valid does not drop.
- After the period-completing handshake, rnd_valid=0 for WARMUP+1 cycles (LOAD + WARM), then returns.
- busy follows the state register, with no combinational path from start.

## Structure
- Shared package rng_pkg: state enum (IDLE, LOAD, WARM, SERVE), SEED_W default, DEFAULT_SEED constant.
- Single module; no sub-module required.
- The LFSR core lives outside this block and is driven through lfsr_load, lfsr_seed and lfsr_step.
- The bench instantiates a 16-bit reference LFSR alongside the block.

## Test plan
- Basic sequence: start with seed_in=16'hACE1, WARMUP=32 → lfsr_load at t+1 with lfsr_seed=16'hACE1, 32 step cycles, rnd_valid at t+34 with rnd_data equal to the 32nd LFSR successor of 16'hACE1.
- Zero seed: start with seed_in=0 → lfsr_seed=16'h5555 during LOAD.
- Backpressure: hold rnd_ready=0 for 10 cycles in SERVE → rnd_data constant and lfsr_step=0 throughout; then rnd_ready=1 for 3 cycles → 3 steps and 3 distinct consecutive words.
- Auto reseed, RESEED_PERIOD=4, seed_in=16'h1234 at the 4th handshake:
  - After the 4th accepted draw, rnd_valid=0 for WARMUP+1 cycles.
  - lfsr_load carries 16'h1234.
  - reseed_cnt=1.
- Ignored and restart requests: start pulsed mid-WARM → no extra lfsr_load and warm-up length unchanged. start in SERVE → immediate LOAD and reseed_cnt unchanged.
- Reset mid-SERVE with rnd_ready=1 → next cycle all outputs 0 and state IDLE. A subsequent start repeats the basic-sequence timing exactly.
